// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU issue stage: ALU opcodes, RV32I major
// opcodes, result-select codes, skid-buffer states and the issued-entry record.
package alu_pkg;

  // ALU operation encodings seen by the execute stage
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0100;
  localparam logic [3:0] ALU_XOR = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_SLL = 4'b1010;
  localparam logic [3:0] ALU_SRA = 4'b1100;
  localparam logic [3:0] ALU_BUF = 4'b1101;

  // RV32I major opcodes (instr[6:0])
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Result select: ALU result, signed less-than flag, unsigned less-than flag
  localparam logic [1:0] SLT_NONE = 2'b00;
  localparam logic [1:0] SLT_LT   = 2'b01;
  localparam logic [1:0] SLT_LTU  = 2'b10;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } skid_state_e;

  // One decoded instruction as it sits in the skid buffer
  typedef struct packed {
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic [4:0]  rd;
    logic        reg_write;
    logic [1:0]  slt_sel;
    logic        is_branch;
    logic [2:0]  br_funct3;
    logic        illegal;
  } issue_t;

  // ALU op for the register/immediate arithmetic groups. instr[30] selects SUB
  // only for register-register ADD, and SRA for either shift-right form.
  function automatic logic [3:0] funct3_alu(input logic [2:0] f3,
                                            input logic       alt,
                                            input logic       allow_sub);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SUB;
      3'b011:  op = ALU_SUB;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Compare instructions reuse the subtractor and pick a flag as the result
  function automatic logic [1:0] funct3_slt(input logic [2:0] f3);
    logic [1:0] sel;
    case (f3)
      3'b010:  sel = SLT_LT;
      3'b011:  sel = SLT_LTU;
      default: sel = SLT_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV32I decoder: turns an instruction, its PC and register
// operands into ALU operands, opcode and writeback/branch control.
module alu_issue_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_ctrl,
  output logic [4:0]  rd,
  output logic        reg_write,
  output logic [1:0]  slt_sel,
  output logic        is_branch,
  output logic [2:0]  br_funct3,
  output logic        illegal
);

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic               alt;
  logic signed [31:0] imm_i;
  logic signed [31:0] imm_s;
  logic [31:0]        imm_u;
  logic [31:0]        shamt_ext;
  logic               shift_imm;
  logic               write_en;

  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign alt       = instr[30];
  assign rd        = instr[11:7];
  assign imm_i     = 32'($signed(instr[31:20]));
  assign imm_s     = 32'($signed({instr[31:25], instr[11:7]}));
  assign imm_u     = {instr[31:12], 12'b0};
  assign shamt_ext = {27'b0, instr[24:20]};
  assign shift_imm = (funct3 == 3'b001) || (funct3 == 3'b101);

  // Decode the major opcode into operands and control; x0 never gets written
  always_comb begin
    alu_a     = '0;
    alu_b     = '0;
    alu_ctrl  = ALU_ADD;
    slt_sel   = SLT_NONE;
    is_branch = 1'b0;
    br_funct3 = 3'b000;
    illegal   = 1'b0;
    write_en  = 1'b0;
    case (opcode)
      OPC_OP: begin
        alu_a    = rs1_data;
        alu_b    = rs2_data;
        alu_ctrl = funct3_alu(funct3, alt, 1'b1);
        slt_sel  = funct3_slt(funct3);
        write_en = 1'b1;
      end
      OPC_OP_IMM: begin
        alu_a    = rs1_data;
        alu_b    = shift_imm ? shamt_ext : imm_i;
        alu_ctrl = funct3_alu(funct3, alt, 1'b0);
        slt_sel  = funct3_slt(funct3);
        write_en = 1'b1;
      end
      OPC_LUI: begin
        alu_b    = imm_u;
        alu_ctrl = ALU_BUF;
        write_en = 1'b1;
      end
      OPC_AUIPC: begin
        alu_a    = pc;
        alu_b    = imm_u;
        write_en = 1'b1;
      end
      OPC_LOAD: begin
        alu_a    = rs1_data;
        alu_b    = imm_i;
        write_en = 1'b1;
      end
      OPC_STORE: begin
        alu_a = rs1_data;
        alu_b = imm_s;
      end
      OPC_BRANCH: begin
        alu_a     = rs1_data;
        alu_b     = rs2_data;
        alu_ctrl  = ALU_SUB;
        is_branch = 1'b1;
        br_funct3 = funct3;
      end
      OPC_JAL, OPC_JALR: begin
        alu_a    = pc;
        alu_b    = 32'd4;
        write_en = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
    reg_write = write_en && (rd != 5'd0);
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes the incoming instruction and holds it in a
// two-entry skid buffer so in_ready can be a flop without losing data.
module alu_issue_stage
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_ctrl,
  output logic [4:0]  rd,
  output logic        reg_write,
  output logic [1:0]  slt_sel,
  output logic        is_branch,
  output logic [2:0]  br_funct3,
  output logic        illegal
);

  issue_t      dec;
  issue_t      head_q, head_d;
  issue_t      skid_q, skid_d;
  skid_state_e state_q, state_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic        accept;
  logic        consume;

  alu_issue_decode u_decode (
    .instr     (instr),
    .pc        (pc),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .alu_a     (dec.alu_a),
    .alu_b     (dec.alu_b),
    .alu_ctrl  (dec.alu_ctrl),
    .rd        (dec.rd),
    .reg_write (dec.reg_write),
    .slt_sel   (dec.slt_sel),
    .is_branch (dec.is_branch),
    .br_funct3 (dec.br_funct3),
    .illegal   (dec.illegal)
  );

  assign accept  = in_valid && in_ready_q;
  assign consume = out_valid_q && out_ready;

  // Next state of the skid buffer; flush empties it ahead of any handshake
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            head_d  = dec;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          case ({accept, consume})
            2'b10: begin
              skid_d  = dec;
              state_d = ST_FULL;
            end
            2'b01: state_d = ST_EMPTY;
            2'b11: head_d = dec;
            default: state_d = ST_ONE;
          endcase
        end
        ST_FULL: begin
          if (consume) begin
            head_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    in_ready_d  = (state_d != ST_FULL);
    out_valid_d = (state_d != ST_EMPTY);
  end

  // Control and the visible head entry; reset wins over flush and handshakes
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      head_q      <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      head_q      <= head_d;
    end
  end

  // Skid entry is only read while FULL, so it needs no reset
  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign alu_a     = head_q.alu_a;
  assign alu_b     = head_q.alu_b;
  assign alu_ctrl  = head_q.alu_ctrl;
  assign rd        = head_q.rd;
  assign reg_write = head_q.reg_write;
  assign slt_sel   = head_q.slt_sel;
  assign is_branch = head_q.is_branch;
  assign br_funct3 = head_q.br_funct3;
  assign illegal   = head_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage: directed instruction and flow-control cases
// followed by randomized traffic, all checked against a queue-based model.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_ctrl;
  logic [4:0]  rd;
  logic        reg_write;
  logic [1:0]  slt_sel;
  logic        is_branch;
  logic [2:0]  br_funct3;
  logic        illegal;

  alu_issue_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .pc        (pc),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_ctrl  (alu_ctrl),
    .rd        (rd),
    .reg_write (reg_write),
    .slt_sel   (slt_sel),
    .is_branch (is_branch),
    .br_funct3 (br_funct3),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic        wr;
    logic [1:0]  slt;
    logic        br;
    logic [2:0]  f3;
    logic        ill;
  } exp_t;

  exp_t mq[$];
  bit   live = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode written straight from the RV32I instruction formats
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] p,
                                      input logic [31:0] ra, input logic [31:0] rb);
    exp_t e;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_u;
    op    = ins[6:0];
    f3    = ins[14:12];
    imm_i = {{20{ins[31]}}, ins[31:20]};
    imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    imm_u = {ins[31:12], 12'h000};
    e     = '0;
    e.rd  = ins[11:7];
    if (op == 7'h33 || op == 7'h13) begin
      e.a  = ra;
      e.b  = (op == 7'h33) ? rb : ((f3 == 3'd1 || f3 == 3'd5) ? {27'd0, ins[24:20]} : imm_i);
      e.wr = 1'b1;
      case (f3)
        3'd0: e.ctrl = (op == 7'h33 && ins[30]) ? 4'b0001 : 4'b0000;
        3'd1: e.ctrl = 4'b1010;
        3'd2: begin e.ctrl = 4'b0001; e.slt = 2'b01; end
        3'd3: begin e.ctrl = 4'b0001; e.slt = 2'b10; end
        3'd4: e.ctrl = 4'b1000;
        3'd5: e.ctrl = ins[30] ? 4'b1100 : 4'b1001;
        3'd6: e.ctrl = 4'b0100;
        default: e.ctrl = 4'b0010;
      endcase
    end else if (op == 7'h37) begin
      e.b = imm_u; e.ctrl = 4'b1101; e.wr = 1'b1;
    end else if (op == 7'h17) begin
      e.a = p; e.b = imm_u; e.wr = 1'b1;
    end else if (op == 7'h03) begin
      e.a = ra; e.b = imm_i; e.wr = 1'b1;
    end else if (op == 7'h23) begin
      e.a = ra; e.b = imm_s;
    end else if (op == 7'h63) begin
      e.a = ra; e.b = rb; e.ctrl = 4'b0001; e.br = 1'b1; e.f3 = f3;
    end else if (op == 7'h6F || op == 7'h67) begin
      e.a = p; e.b = 32'd4; e.wr = 1'b1;
    end else begin
      e.ill = 1'b1;
    end
    if (e.rd == 5'd0) e.wr = 1'b0;
    return e;
  endfunction

  // Model of the stage as an in-order queue of at most two entries
  function automatic void model_step();
    bit acc, con;
    if (rst) begin
      mq.delete();
      live = 1'b1;
    end else if (live) begin
      if (flush) begin
        mq.delete();
      end else begin
        acc = in_valid && (mq.size() < 2);
        con = out_ready && (mq.size() > 0);
        if (con) void'(mq.pop_front());
        if (acc) mq.push_back(ref_decode(instr, pc, rs1_data, rs2_data));
      end
    end
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] r1, input bit ordy);
    in_valid  = v;
    instr     = ins;
    pc        = 32'h0000_1000;
    rs1_data  = r1;
    rs2_data  = 32'h0000_0077;
    out_ready = ordy;
    flush     = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 10))
      0, 1:    r[6:0] = 7'h33;
      2, 3:    r[6:0] = 7'h13;
      4:       r[6:0] = 7'h37;
      5:       r[6:0] = 7'h17;
      6:       r[6:0] = 7'h03;
      7:       r[6:0] = 7'h23;
      8:       r[6:0] = 7'h63;
      9:       r[6:0] = ($urandom_range(0, 1) == 0) ? 7'h6F : 7'h67;
      default: r[6:0] = 7'h7F;
    endcase
    return r;
  endfunction

  // Every cycle: flow-control flags and the head entry against the model
  always @(negedge clk) begin
    if (live) begin
      chk("in_ready", in_ready, 32'(mq.size() < 2));
      chk("out_valid", out_valid, 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("alu_a", alu_a, mq[0].a);
        chk("alu_b", alu_b, mq[0].b);
        chk("alu_ctrl", alu_ctrl, mq[0].ctrl);
        chk("rd", rd, mq[0].rd);
        chk("reg_write", reg_write, mq[0].wr);
        chk("slt_sel", slt_sel, mq[0].slt);
        chk("is_branch", is_branch, mq[0].br);
        chk("br_funct3", br_funct3, mq[0].f3);
        chk("illegal", illegal, mq[0].ill);
      end
    end
  end

  initial begin
    int   got[$];
    bit   acc_now;
    exp_t e;

    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0);

    // Model pins against hand-decoded instructions
    e = ref_decode(32'h00500093, 32'h0, 32'h0, 32'h0);
    chk("model_addi_b", e.b, 32'd5);
    e = ref_decode(32'h00001117, 32'h40, 32'h0, 32'h0);
    chk("model_auipc_a", e.a, 32'h40);
    chk("model_auipc_b", e.b, 32'h1000);
    e = ref_decode(32'h0050B193, 32'h0, 32'h0, 32'h0);
    chk("model_sltiu", {e.ctrl, e.slt}, {26'd0, 4'b0001, 2'b10});
    e = ref_decode(32'h00208463, 32'h0, 32'h0, 32'h9);
    chk("model_beq", {e.br, e.wr, e.ctrl}, {26'd0, 1'b1, 1'b0, 4'b0001});

    cycle();
    cycle();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 32'd1);
    chk("rst_out_valid", out_valid, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_ctrl_rd_wr", {alu_ctrl, rd, reg_write, slt_sel, is_branch, br_funct3, illegal}, 32'd0);

    // ADDI x1, x0, 5
    drive(1'b1, 32'h00500093, 32'h0, 1'b1);
    cycle();
    in_valid = 1'b0;
    chk("addi_alu_a", alu_a, 32'd0);
    chk("addi_alu_b", alu_b, 32'd5);
    chk("addi_ctrl", alu_ctrl, 32'h0);
    chk("addi_rd", rd, 32'd1);
    chk("addi_wr", reg_write, 32'd1);
    chk("addi_valid", out_valid, 32'd1);
    cycle();

    // SRAI x1, x1, 3
    drive(1'b1, 32'h4030D093, 32'h80000000, 1'b1);
    cycle();
    in_valid = 1'b0;
    chk("srai_ctrl", alu_ctrl, 32'hC);
    chk("srai_b", alu_b, 32'd3);
    chk("srai_a", alu_a, 32'h80000000);
    cycle();

    // LUI x5, 0x12345
    drive(1'b1, 32'h123452B7, 32'h0, 1'b1);
    cycle();
    in_valid = 1'b0;
    chk("lui_ctrl", alu_ctrl, 32'hD);
    chk("lui_b", alu_b, 32'h12345000);
    chk("lui_rd", rd, 32'd5);
    cycle();

    // Illegal opcode still flows through
    drive(1'b1, 32'h0000007F, 32'h1234, 1'b1);
    cycle();
    in_valid = 1'b0;
    chk("ill_flag", illegal, 32'd1);
    chk("ill_wr", reg_write, 32'd0);
    chk("ill_ctrl", alu_ctrl, 32'h0);
    chk("ill_valid", out_valid, 32'd1);
    cycle();

    // Backpressure: three back-to-back inputs, only two fit
    drive(1'b1, 32'h00100093, 32'h0, 1'b0);
    cycle();
    drive(1'b1, 32'h00200093, 32'h0, 1'b0);
    cycle();
    chk("bp_full_ready", in_ready, 32'd0);
    drive(1'b1, 32'h00300093, 32'h0, 1'b0);
    cycle();
    chk("bp_stall_ready", in_ready, 32'd0);
    chk("bp_stall_head", alu_b, 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) got.push_back(int'(alu_b));
      acc_now = in_valid && in_ready;
      cycle();
      if (acc_now) in_valid = 1'b0;
    end
    chk("bp_count", got.size(), 32'd3);
    for (int j = 0; j < got.size() && j < 3; j++) chk("bp_order", got[j], j + 1);

    // Flush while FULL with an input pending
    drive(1'b1, 32'h00400093, 32'h0, 1'b0);
    cycle();
    drive(1'b1, 32'h00500093, 32'h0, 1'b0);
    cycle();
    drive(1'b1, 32'h00600093, 32'h0, 1'b0);
    flush = 1'b1;
    cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", out_valid, 32'd0);
    chk("flush_ready", in_ready, 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("flush_no_leak", out_valid, 32'd0);
    end

    // Flush while ONE drops an input that would otherwise be accepted
    drive(1'b1, 32'h00700093, 32'h0, 1'b0);
    cycle();
    drive(1'b1, 32'h00800093, 32'h0, 1'b0);
    flush = 1'b1;
    cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_one_valid", out_valid, 32'd0);

    // Reset mid-transfer beats the handshake
    drive(1'b1, 32'h00900093, 32'h0, 1'b0);
    cycle();
    drive(1'b1, 32'h00A00093, 32'h0, 1'b0);
    cycle();
    drive(1'b1, 32'h00B00093, 32'h0, 1'b1);
    flush = 1'b1;
    rst   = 1'b1;
    cycle();
    rst      = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("rst_mid_valid", out_valid, 32'd0);
    chk("rst_mid_ready", in_ready, 32'd1);
    chk("rst_mid_b", alu_b, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      instr     = rand_instr();
      pc        = $urandom;
      rs1_data  = $urandom;
      rs2_data  = $urandom;
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 49) == 0);
      rst       = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 SHALL have port clk, input, 1: rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-003 SHALL have port in_valid, input, 1: decode stage presents an instruction.
REQ-004 SHALL have port in_ready, output, 1: stage accepts the instruction; registered.
REQ-005 SHALL have ports instr and pc, input, 32 each: instruction word and its PC.
REQ-006 SHALL have ports rs1_data and rs2_data, input, 32 each: register-file read data.
REQ-007 SHALL have port flush, input, 1: discard all held and incoming instructions.
REQ-008 SHALL have port out_valid, output, 1: the head entry is valid.
REQ-009 SHALL have port out_ready, input, 1: the execute stage consumes the head entry.
REQ-010 SHALL have ports alu_a and alu_b, output, 32 each: ALU operands.
REQ-011 SHALL have port alu_ctrl, output, 4: ALU opcode.
- Encodings: ADD 0000, SUB 0001, AND 0010, OR 0100, XOR 1000, SRL 1001, SLL 1010, SRA 1100, BUF 1101.
REQ-012 SHALL have ports rd (output, 5) and reg_write (output, 1).
REQ-013 SHALL have port slt_sel, output, 2: result select.
- 00 = ALU result; 01 = lt flag; 10 = ltu flag.
REQ-014 SHALL have ports is_branch (output, 1), br_funct3 (output, 3) and illegal (output, 1).

Function
REQ-015 SHALL decode each opcode as follows:
- OP (0110011): alu_a=rs1, alu_b=rs2.
- OP-IMM (0010011): alu_a=rs1, alu_b=sign-extended I-immediate.
- SUB only when OP with instr[30]=1.
- SRA/SRAI when funct3=101 and instr[30]=1.
- Shift-immediate alu_b={27'b0, instr[24:20]}.
REQ-016 SHALL map SLT and SLTI to SUB with slt_sel=01, and SLTU and SLTIU to SUB with slt_sel=10.
REQ-017 SHALL decode LUI as BUF with alu_b=U-immediate.
REQ-018 SHALL decode AUIPC as ADD with alu_a=pc and alu_b=U-immediate.
REQ-019 SHALL decode LOAD and STORE as ADD with alu_a=rs1 and sign-extended I- or S-immediate.
- reg_write=1 for LOAD only.
REQ-020 SHALL decode BRANCH as SUB with alu_a=rs1, alu_b=rs2, is_branch=1, br_funct3=funct3 and reg_write=0.
REQ-021 SHALL decode JAL and JALR as ADD with alu_a=pc, alu_b=4 and reg_write=1.
REQ-022 SHALL treat any other opcode as illegal:
- illegal=1, alu_ctrl=ADD, reg_write=0, is_branch=0.
- The entry still flows through the stage.
REQ-023 SHALL force reg_write=0 whenever rd=0.
REQ-024 SHALL buffer entries in a two-entry skid buffer with states EMPTY, ONE and FULL.
REQ-025 SHALL accept an input only when in_valid=1 and in_ready=1.
REQ-026 SHALL drive in_ready=1 in EMPTY and ONE, and in_ready=0 in FULL.
REQ-027 SHALL hold out_valid=0 in EMPTY and out_valid=1 in ONE and FULL.
REQ-028 SHALL consume the head entry when out_valid=1 and out_ready=1.
REQ-029 SHALL apply these state transitions:
- EMPTY to ONE on accept.
- ONE to FULL on accept without consume.
- ONE to EMPTY on consume without accept.
- ONE stays ONE on simultaneous accept and consume.
- FULL to ONE on consume.
REQ-030 SHALL have latency of exactly one cycle: an entry accepted in cycle N is visible on the outputs in cycle N+1.
REQ-031 SHALL preserve FIFO order through the skid entry.
REQ-032 SHALL keep every output stable while out_valid=1 and out_ready=0.
REQ-033 SHALL, on flush=1, discard both entries and any same-cycle input and enter EMPTY next cycle.
- flush has priority over accept and consume.

Reset
REQ-034 SHALL, on rst=1 at a clk edge, enter EMPTY.
REQ-035 SHALL drive every registered output to zero after reset, except in_ready=1.
REQ-036 SHALL give rst priority over flush and handshakes, including when asserted mid-transfer.

Structure
REQ-037 SHALL place the alu_ctrl encodings, the RV32I opcode constants and the slt_sel codes in a shared package, alu_pkg.
REQ-038 SHALL implement decoding in one combinational sub-module, alu_issue_decode.
- The skid-buffer state machine stays in the top module.

Verification
REQ-039 SHALL check ADDI: instr=0x00500093, rs1_data=0.
- Next cycle: alu_a=0, alu_b=5, alu_ctrl=0000, rd=1, reg_write=1, out_valid=1.
REQ-040 SHALL check SRAI: instr=0x4030D093, rs1_data=0x80000000.
- Expect alu_ctrl=1100, alu_b=3, alu_a=0x80000000.
REQ-041 SHALL check LUI: instr=0x123452B7.
- Expect alu_ctrl=1101, alu_b=0x12345000, rd=5.
REQ-042 SHALL check backpressure: out_ready=0, three back-to-back inputs.
- Two inputs are accepted; in_ready=0 in the cycle after the second accept.
- After out_ready=1, outputs appear in order 1, 2, 3 with no loss or duplicate.
REQ-043 SHALL check flush while FULL, with in_valid=1.
- Next cycle: out_valid=0 and in_ready=1.
- The flushed-cycle input never appears on the outputs.
REQ-044 SHALL check illegal opcode: instr=0x0000007F.
- Expect illegal=1, reg_write=0, alu_ctrl=0000, out_valid=1.
